// File: rtl/dnlink_pkg.sv
// Shared definitions for the AGC telemetry downlink sequencer:
// the FSM state encoding and the default timing constants.
package dnlink_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    END,
    GAP
  } dnlink_state_t;

  localparam int DNL_PULSE_DIV   = 20;
  localparam int DNL_PULSE_WIDTH = 4;
  localparam int DNL_WORD_PERIOD = 1024;
  localparam int DNL_NBITS       = 40;

endpackage

// File: rtl/dnlink_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with an optional
// one-clk strobe on each rising edge of the synchronised level.
module dnlink_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sync_out;
      end

      assign rise = sync_out & ~prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/dnlink_sequencer.sv
// AGC telemetry downlink sequencer: DKSTRT/DKBSNC/DKEND pulse trains timed from
// AGC CLK, DKDATA word capture and valid/ready hand-off. Option: DNLINK_WORDCNT_EN.
module dnlink_sequencer
  import dnlink_pkg::*;
#(
  parameter int PULSE_DIV   = DNL_PULSE_DIV,
  parameter int PULSE_WIDTH = DNL_PULSE_WIDTH,
  parameter int WORD_PERIOD = DNL_WORD_PERIOD,
  parameter int NBITS       = DNL_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             agc_clk_in,
  input  logic             dkdata_in,
  output logic             dkstrt,
  output logic             dkbsnc,
  output logic             dkend,
  output logic [NBITS-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy
`ifdef DNLINK_WORDCNT_EN
  ,
  output logic [15:0]      word_count,
  output logic [7:0]       drop_count
`endif
);

  localparam int PTW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam int WTW = $clog2(WORD_PERIOD);
  localparam int BCW = $clog2(NBITS);
  localparam logic [PTW-1:0] PT_LAST  = PTW'(PULSE_DIV - 1);
  localparam logic [PTW-1:0] PT_WIDTH = PTW'(PULSE_WIDTH);
  localparam logic [WTW-1:0] WT_LAST  = WTW'(WORD_PERIOD - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(NBITS - 1);

  dnlink_state_t    state, state_n;
  logic [PTW-1:0]   ptmr, ptmr_n;
  logic [WTW-1:0]   wtmr, wtmr_n;
  logic [BCW-1:0]   bcnt, bcnt_n;
  logic [NBITS-1:0] shreg, shreg_n;
  logic             dkstrt_n, dkbsnc_n, dkend_n;
  logic             tick, dk_sync, agc_sync_unused, dk_rise_unused;
  logic             bit_boundary, slot_wrap, capture, complete, load, drop;

  dnlink_sync_edge #(.EDGE_EN(1'b1)) u_agc_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (agc_clk_in),
    .sync_out (agc_sync_unused),
    .rise     (tick)
  );

  dnlink_sync_edge #(.EDGE_EN(1'b0)) u_dk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (dkdata_in),
    .sync_out (dk_sync),
    .rise     (dk_rise_unused)
  );

  assign bit_boundary = tick && (ptmr == PT_LAST);
  assign slot_wrap    = enable && bit_boundary && (wtmr == WT_LAST);
  assign busy         = (state == START) || (state == BITS) || (state == END);

  always_comb begin
    ptmr_n = ptmr;
    if (tick) ptmr_n = (ptmr == PT_LAST) ? '0 : ptmr + 1'b1;

    // Slot timer parks on its last count while disabled, so the first slot opens on the next boundary.
    wtmr_n = wtmr;
    if (!enable)           wtmr_n = WT_LAST;
    else if (bit_boundary) wtmr_n = (wtmr == WT_LAST) ? '0 : wtmr + 1'b1;

    state_n = state;
    bcnt_n  = bcnt;
    unique case (state)
      IDLE:  if (slot_wrap) state_n = START;
      START: begin
        if (!enable) state_n = IDLE;
        else if (bit_boundary) begin
          state_n = BITS;
          bcnt_n  = '0;
        end
      end
      BITS: begin
        if (!enable) state_n = IDLE;
        else if (bit_boundary) begin
          if (bcnt == BC_LAST) state_n = END;
          else                 bcnt_n  = bcnt + 1'b1;
        end
      end
      END: begin
        if (!enable)           state_n = IDLE;
        else if (bit_boundary) state_n = GAP;
      end
      GAP: begin
        if (!enable)       state_n = IDLE;
        else if (slot_wrap) state_n = START;
      end
      default: state_n = IDLE;
    endcase

    dkstrt_n = (state_n == START) && (ptmr_n < PT_WIDTH);
    dkbsnc_n = (state_n == BITS)  && (ptmr_n < PT_WIDTH);
    dkend_n  = (state_n == END)   && (ptmr_n < PT_WIDTH);

    // DKDATA is sampled where the bit-sync pulse falls.
    capture = (state == BITS) && tick && (ptmr_n == PT_WIDTH);
    shreg_n = capture ? {shreg[NBITS-2:0], dk_sync} : shreg;

    complete = (state == BITS) && (state_n == END);
    load     = complete && (!word_valid || word_ready);
    drop     = complete && word_valid && !word_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptmr   <= '0;
      wtmr   <= WT_LAST;
      bcnt   <= '0;
      shreg  <= '0;
      dkstrt <= 1'b0;
      dkbsnc <= 1'b0;
      dkend  <= 1'b0;
    end else begin
      state  <= state_n;
      ptmr   <= ptmr_n;
      wtmr   <= wtmr_n;
      bcnt   <= bcnt_n;
      shreg  <= shreg_n;
      dkstrt <= dkstrt_n;
      dkbsnc <= dkbsnc_n;
      dkend  <= dkend_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        word_data  <= shreg;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef DNLINK_WORDCNT_EN
  // A clear coinciding with a load or drop keeps that event in the restarted count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      drop_count <= '0;
    end else if (ovf_clr) begin
      word_count <= {15'd0, load};
      drop_count <= {7'd0, drop};
    end else begin
      if (load)                        word_count <= word_count + 16'd1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule
